dequant_round_clip: RTL

//  H.265 dequantisation stage for residual coefficients: level x scale, scaled by 2^qp_per,

---
 rtl/dequant_round_clip_pkg.sv | 57 +++++
 rtl/dequant_round_clip_mult.sv | 39 +++
 rtl/dequant_round_clip.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dequant_round_clip_pkg.sv
// Shared constants, FIFO entry type and the round/shift/clip helper for the
// H.265 residual dequantiser. There are no ports in this file.
package dequant_round_clip_pkg;

  localparam int LEVEL_BITS    = 16;
  localparam int SCALE_BITS    = 8;
  localparam int PROD_BITS     = 26;
  localparam int EXT_BITS      = 40;
  localparam int FIFO_DEPTH    = 4;

  localparam int COEFF_BITS    = 16;
  localparam int QP_PER_BITS   = 4;
  localparam int BD_SHIFT_BITS = 5;
  localparam int COEFF_MAX     = 32767;
  localparam int COEFF_MIN     = -32768;

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int OCC_BITS = CNT_BITS + 1;

  localparam logic signed [EXT_BITS-1:0] EXT_MAX     = EXT_BITS'(COEFF_MAX);
  localparam logic signed [EXT_BITS-1:0] EXT_MIN     = EXT_BITS'(COEFF_MIN);
  localparam logic [COEFF_BITS-1:0]      COEFF_MAX_C = COEFF_BITS'(COEFF_MAX);
  localparam logic [COEFF_BITS-1:0]      COEFF_MIN_C = COEFF_BITS'(COEFF_MIN);

  typedef struct packed {
    logic                  last;
    logic [COEFF_BITS-1:0] coeff;
  } fifo_entry_t;

  // Product is widened before the left shift so qp_per up to 15 cannot overflow.
  // The rounding offset is added before the arithmetic shift, so negative
  // values round towards +inf at exact halves (floor of x + 0.5).
  function automatic logic [COEFF_BITS-1:0] round_shift_clip(
    input logic [PROD_BITS-1:0]     prod,
    input logic [QP_PER_BITS-1:0]   qp_per,
    input logic [BD_SHIFT_BITS-1:0] bd_shift
  );
    logic signed [EXT_BITS-1:0] ext;
    logic signed [EXT_BITS-1:0] shifted;
    logic signed [EXT_BITS-1:0] rounded;
    logic signed [EXT_BITS-1:0] res;
    logic [EXT_BITS-1:0]        half;
    ext     = {{(EXT_BITS-PROD_BITS){prod[PROD_BITS-1]}}, prod};
    shifted = ext <<< qp_per;
    half    = {{(EXT_BITS-1){1'b0}}, 1'b1} << (bd_shift - BD_SHIFT_BITS'(1));
    rounded = shifted + $signed(half);
    res     = rounded >>> bd_shift;
    if (res > EXT_MAX) begin
      return COEFF_MAX_C;
    end else if (res < EXT_MIN) begin
      return COEFF_MIN_C;
    end
    return res[COEFF_BITS-1:0];
  endfunction

endpackage

// File: rtl/dequant_round_clip_mult.sv
// Registered signed multiplier. No enable: a new product is captured on every
// rising edge, so the consumer decides which products are meaningful.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   a_i    signed multiplicand, a_bits wide
//   b_i    signed multiplier, b_bits wide
//   p_o    registered signed product, p_bits wide (p_bits > a_bits, b_bits)
module dequant_round_clip_mult #(
  parameter int a_bits = 16,
  parameter int b_bits = 8,
  parameter int p_bits = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [a_bits-1:0] a_i,
  input  logic [b_bits-1:0] b_i,
  output logic [p_bits-1:0] p_o
);

  logic signed [p_bits-1:0] a_ext;
  logic signed [p_bits-1:0] b_ext;
  logic signed [p_bits-1:0] p_d;

  // Operands are sign-extended to the product width; the true product always
  // fits, so truncation of the p_bits-wide multiply is exact.
  assign a_ext = {{(p_bits-a_bits){a_i[a_bits-1]}}, a_i};
  assign b_ext = {{(p_bits-b_bits){b_i[b_bits-1]}}, b_i};
  assign p_d   = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_o <= '0;
    end else begin
      p_o <= p_d;
    end
  end

endmodule

// File: rtl/dequant_round_clip.sv
// H.265 residual dequantiser: level*scale via a registered multiplier, then
// << qp_per, rounded >>> bd_shift, clipped to 16-bit signed, and queued in a
// small output FIFO. Admission is credit based so the FIFO never overflows
// even though the multiplier cannot stall.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           synchronous clear of FIFO and the in-flight beat
//   in_valid/ready  input handshake
//   in_level        signed coefficient level
//   in_scale        signed scale (legal 0..127)
//   in_qp_per       left shift 0..15
//   in_bd_shift     right shift 1..20
//   in_last         sideband, travels with the coefficient
//   out_valid/ready output handshake (out_valid = FIFO non-empty)
//   out_coeff       FIFO head coefficient
//   out_last        FIFO head sideband
module dequant_round_clip
  import dequant_round_clip_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LEVEL_BITS-1:0]    in_level,
  input  logic [SCALE_BITS-1:0]    in_scale,
  input  logic [QP_PER_BITS-1:0]   in_qp_per,
  input  logic [BD_SHIFT_BITS-1:0] in_bd_shift,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COEFF_BITS-1:0]    out_coeff,
  output logic                     out_last
);

  logic [PROD_BITS-1:0]     prod;

  logic                     s1_valid_q;
  logic                     s1_valid_d;
  logic [QP_PER_BITS-1:0]   s1_qp_per_q;
  logic [BD_SHIFT_BITS-1:0] s1_bd_shift_q;
  logic                     s1_last_q;

  logic [PTR_BITS-1:0]      wr_ptr_q;
  logic [PTR_BITS-1:0]      wr_ptr_d;
  logic [PTR_BITS-1:0]      rd_ptr_q;
  logic [PTR_BITS-1:0]      rd_ptr_d;
  logic [CNT_BITS-1:0]      count_q;
  logic [CNT_BITS-1:0]      count_d;
  fifo_entry_t              mem_q [FIFO_DEPTH];
  fifo_entry_t              push_entry;

  logic                     fire;
  logic                     push;
  logic                     pop;
  logic [OCC_BITS-1:0]      occupancy;

  dequant_round_clip_mult #(
    .a_bits (LEVEL_BITS),
    .b_bits (SCALE_BITS),
    .p_bits (PROD_BITS)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst),
    .a_i   (in_level),
    .b_i   (in_scale),
    .p_o   (prod)
  );

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = s1_valid_q;

  // Occupancy after this edge, counting the beat already inside the
  // multiplier; a new beat is only taken if it will still have a slot.
  assign occupancy = {1'b0, count_q}
                   + {{CNT_BITS{1'b0}}, s1_valid_q}
                   - {{CNT_BITS{1'b0}}, pop};
  assign in_ready  = ~flush & (occupancy < OCC_BITS'(FIFO_DEPTH));
  assign fire      = in_valid & in_ready;

  assign push_entry.last  = s1_last_q;
  assign push_entry.coeff = round_shift_clip(prod, s1_qp_per_q, s1_bd_shift_q);

  assign out_coeff = mem_q[rd_ptr_q].coeff;
  assign out_last  = mem_q[rd_ptr_q].last;

  always_comb begin
    s1_valid_d = fire;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      end
      count_d = count_q + {{(CNT_BITS-1){1'b0}}, push}
                        - {{(CNT_BITS-1){1'b0}}, pop};
    end
  end

  // Sideband loads every cycle, mirroring the multiplier; it only matters
  // when s1_valid_q marks the product as a real beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q    <= 1'b0;
      s1_qp_per_q   <= '0;
      s1_bd_shift_q <= '0;
      s1_last_q     <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_qp_per_q   <= in_qp_per;
      s1_bd_shift_q <= in_bd_shift;
      s1_last_q     <= in_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!flush && push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule
